// File: rtl/pipe_perf_counter.sv
// Per-cycle event monitor: cycle counter plus NUM_EVT event counters with run
// limit, freeze, sticky overflow flags and a coherent snapshot bank.

module pipe_perf_lane #(
  parameter int CNT_W = 32,
  parameter int SAT   = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             snap_i,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] snap_cnt,
  output logic             ovf
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      snap_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clr_i) begin
      cnt      <= '0;
      snap_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      if (inc_i) begin
        if (&cnt) begin
          cnt <= (SAT != 0) ? '1 : '0;
          ovf <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      // snapshot takes the pre-edge value so all lanes see the same instant
      if (snap_i) snap_cnt <= cnt;
    end
  end
endmodule

module pipe_perf_counter #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SAT     = 0,
  parameter int SEL_W   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clr_i,
  input  logic               freeze_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [CNT_W-1:0]   cycle_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [CNT_W-1:0]   snap_cyc_o,
  output logic [CNT_W-1:0]   snap_o,
  output logic               snap_vld_o,
  output logic [NUM_EVT-1:0] ovf_o,
  output logic               done_o,
  output logic [1:0]         state_o
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_HOLD = 2'b10, S_DONE = 2'b11} state_t;

  localparam int NSEL = 2**SEL_W;

  state_t                       state, state_d;
  logic                         en, hit;
  logic [CNT_W-1:0]             cyc, cyc_inc, snap_cyc;
  logic [NSEL-1:0][CNT_W-1:0]   cnt_a, snap_a;

  always_comb begin
    en      = (state == S_RUN) && start_i && !freeze_i && !clr_i;
    cyc_inc = cyc + CNT_W'(1);
    hit     = en && (limit_i != '0) && (cyc_inc == limit_i);
    state_d = state;
    if (clr_i) state_d = S_IDLE;
    else begin
      case (state)
        S_IDLE: if (start_i) state_d = freeze_i ? S_HOLD : S_RUN;
        S_RUN: begin
          if (hit)           state_d = S_DONE;
          else if (freeze_i) state_d = S_HOLD;
          else if (!start_i) state_d = S_IDLE;
        end
        S_HOLD: if (!freeze_i) state_d = start_i ? S_RUN : S_IDLE;
        default: state_d = S_DONE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc        <= '0;
      snap_cyc   <= '0;
      snap_vld_o <= 1'b0;
    end else if (clr_i) begin
      cyc        <= '0;
      snap_cyc   <= '0;
      snap_vld_o <= 1'b0;
    end else begin
      if (en) cyc <= ((&cyc) && (SAT != 0)) ? cyc : cyc_inc;
      if (snap_i) snap_cyc <= cyc;
      snap_vld_o <= snap_i;
    end
  end

  // readback table padded to the full select range; unused slots read 0
  for (genvar i = 0; i < NSEL; i++) begin : g_lane
    if (i < NUM_EVT) begin : g_on
      pipe_perf_lane #(.CNT_W(CNT_W), .SAT(SAT)) u_lane (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .inc_i   (en & evt_i[i]),
        .snap_i  (snap_i),
        .cnt     (cnt_a[i]),
        .snap_cnt(snap_a[i]),
        .ovf     (ovf_o[i])
      );
    end else begin : g_off
      assign cnt_a[i]  = '0;
      assign snap_a[i] = '0;
    end
  end

  assign cycle_o    = cyc;
  assign snap_cyc_o = snap_cyc;
  assign cnt_o      = cnt_a[sel_i];
  assign snap_o     = snap_a[sel_i];
  assign done_o     = (state == S_DONE);
  assign state_o    = state;
endmodule

// File: tb/tb_pipe_perf_counter.sv
// Directed bench for pipe_perf_counter: 32-bit instance plus two 4-bit
// instances (wrap and saturate) sharing the same stimulus.

module tb_pipe_perf_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, clr = 1'b0, freeze = 1'b0, snap = 1'b0;
  logic [3:0]  evt = '0;
  logic [31:0] limit = '0;
  logic [1:0]  sel = '0;

  logic [31:0] cycle, cnt, snap_cyc, snap_cnt;
  logic        snap_vld, done;
  logic [3:0]  ovf;
  logic [1:0]  state;

  logic [3:0]  cycle_w, cnt_w, scyc_w, snap_w, ovf_w;
  logic        vld_w, done_w;
  logic [1:0]  state_w;
  logic [3:0]  cycle_s, cnt_s, scyc_s, snap_s, ovf_s;
  logic        vld_s, done_s;
  logic [1:0]  state_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_perf_counter dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clr_i(clr),
    .freeze_i(freeze), .limit_i(limit), .snap_i(snap), .sel_i(sel),
    .cycle_o(cycle), .cnt_o(cnt), .snap_cyc_o(snap_cyc), .snap_o(snap_cnt),
    .snap_vld_o(snap_vld), .ovf_o(ovf), .done_o(done), .state_o(state)
  );

  pipe_perf_counter #(.CNT_W(4), .SAT(0)) dut_w (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clr_i(clr),
    .freeze_i(freeze), .limit_i(4'd0), .snap_i(snap), .sel_i(sel),
    .cycle_o(cycle_w), .cnt_o(cnt_w), .snap_cyc_o(scyc_w), .snap_o(snap_w),
    .snap_vld_o(vld_w), .ovf_o(ovf_w), .done_o(done_w), .state_o(state_w)
  );

  pipe_perf_counter #(.CNT_W(4), .SAT(1)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .evt_i(evt), .clr_i(clr),
    .freeze_i(freeze), .limit_i(4'd0), .snap_i(snap), .sel_i(sel),
    .cycle_o(cycle_s), .cnt_o(cnt_s), .snap_cyc_o(scyc_s), .snap_o(snap_s),
    .snap_vld_o(vld_s), .ovf_o(ovf_s), .done_o(done_s), .state_o(state_s)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    total++; if (cycle !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%0d exp=0", cycle); end
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", state); end
    total++; if ({done, snap_vld, ovf} !== 6'd0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {done, snap_vld, ovf}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    start = 1'b1; evt = 4'b0101;
    tick();                      // IDLE->RUN entry edge, no count
    for (int i = 0; i < 10; i++) tick();
    total++; if (cycle !== 32'd10) begin bad++; $display("FAIL basic_cycle got=%0d exp=10", cycle); end
    sel = 2'd0; #1;
    total++; if (cnt !== 32'd10) begin bad++; $display("FAIL basic_ch0 got=%0d exp=10", cnt); end
    sel = 2'd1; #1;
    total++; if (cnt !== 32'd0) begin bad++; $display("FAIL basic_ch1 got=%0d exp=0", cnt); end
    sel = 2'd2; #1;
    total++; if (cnt !== 32'd10) begin bad++; $display("FAIL basic_ch2 got=%0d exp=10", cnt); end
    total++; if (state !== 2'b01) begin bad++; $display("FAIL basic_state got=%b exp=01", state); end
  endtask

  task automatic test_limit();
    clr = 1'b1; evt = '0; tick();
    clr = 1'b0; limit = 32'd30; start = 1'b1;
    tick();                      // entry edge
    for (int i = 1; i <= 29; i++) begin
      evt = (i >= 3 && i <= 7) ? 4'b0010 : 4'b0000;
      tick();
    end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL limit_early_done got=%b exp=0", done); end
    evt = '0; tick();
    sel = 2'd1; #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL limit_done got=%b exp=1", done); end
    total++; if (cycle !== 32'd30) begin bad++; $display("FAIL limit_cycle got=%0d exp=30", cycle); end
    total++; if (state !== 2'b11) begin bad++; $display("FAIL limit_state got=%b exp=11", state); end
    total++; if (cnt !== 32'd5) begin bad++; $display("FAIL limit_ch1 got=%0d exp=5", cnt); end
    evt = 4'b1111; freeze = 1'b1; tick(); freeze = 1'b0; tick(); tick();
    total++; if (cycle !== 32'd30 || cnt !== 32'd5) begin bad++; $display("FAIL limit_hold got=%0d/%0d exp=30/5", cycle, cnt); end
    total++; if (state !== 2'b11) begin bad++; $display("FAIL limit_stay got=%b exp=11", state); end
    clr = 1'b1; tick(); clr = 1'b0;
    total++; if (cycle !== 32'd0 || cnt !== 32'd0) begin bad++; $display("FAIL limit_clr got=%0d/%0d exp=0/0", cycle, cnt); end
    total++; if (state !== 2'b00 || done !== 1'b0) begin bad++; $display("FAIL limit_clr_state got=%b/%b exp=00/0", state, done); end
    limit = '0;
  endtask

  task automatic test_freeze();
    start = 1'b1; evt = 4'b1111; sel = 2'd3;
    tick();                      // entry
    tick(); tick(); tick();
    total++; if (cycle !== 32'd3) begin bad++; $display("FAIL frz_pre got=%0d exp=3", cycle); end
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    total++; if (state !== 2'b10) begin bad++; $display("FAIL frz_state got=%b exp=10", state); end
    total++; if (cycle !== 32'd3 || cnt !== 32'd3) begin bad++; $display("FAIL frz_hold got=%0d/%0d exp=3/3", cycle, cnt); end
    freeze = 1'b0;
    tick();                      // HOLD->RUN edge, not yet counting
    total++; if (state !== 2'b01 || cycle !== 32'd3) begin bad++; $display("FAIL frz_exit got=%b/%0d exp=01/3", state, cycle); end
    tick();
    total++; if (cycle !== 32'd4 || cnt !== 32'd4) begin bad++; $display("FAIL frz_resume got=%0d/%0d exp=4/4", cycle, cnt); end
  endtask

  task automatic test_overflow();
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; evt = 4'b0001; sel = 2'd0;
    tick();                      // entry
    for (int i = 0; i < 17; i++) tick();
    total++; if (cnt_w !== 4'd1 || ovf_w !== 4'b0001) begin bad++; $display("FAIL ovf_wrap got=%0d/%b exp=1/0001", cnt_w, ovf_w); end
    total++; if (cycle_w !== 4'd1) begin bad++; $display("FAIL ovf_wrap_cyc got=%0d exp=1", cycle_w); end
    total++; if (cnt_s !== 4'd15 || ovf_s !== 4'b0001) begin bad++; $display("FAIL ovf_sat got=%0d/%b exp=15/0001", cnt_s, ovf_s); end
    total++; if (cycle_s !== 4'd15) begin bad++; $display("FAIL ovf_sat_cyc got=%0d exp=15", cycle_s); end
    total++; if (cnt !== 32'd17 || ovf !== 4'b0000) begin bad++; $display("FAIL ovf_wide got=%0d/%b exp=17/0000", cnt, ovf); end
  endtask

  task automatic test_snapshot();
    clr = 1'b1; tick(); clr = 1'b0;
    start = 1'b1; sel = 2'd2; evt = 4'b0100;
    tick();                      // entry
    for (int i = 0; i < 7; i++) begin
      evt = (i < 3) ? 4'b0100 : 4'b0000;
      tick();
    end
    total++; if (cycle !== 32'd7 || cnt !== 32'd3) begin bad++; $display("FAIL snap_pre got=%0d/%0d exp=7/3", cycle, cnt); end
    snap = 1'b1; evt = 4'b0100;
    tick();
    total++; if (snap_vld !== 1'b1) begin bad++; $display("FAIL snap_vld got=%b exp=1", snap_vld); end
    snap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 0) begin
        total++; if (snap_vld !== 1'b0) begin bad++; $display("FAIL snap_vld_pulse got=%b exp=0", snap_vld); end
      end
    end
    total++; if (snap_cnt !== 32'd3) begin bad++; $display("FAIL snap_ch2 got=%0d exp=3", snap_cnt); end
    total++; if (snap_cyc !== 32'd7) begin bad++; $display("FAIL snap_cyc got=%0d exp=7", snap_cyc); end
    total++; if (cnt !== 32'd8) begin bad++; $display("FAIL snap_live got=%0d exp=8", cnt); end
    snap = 1'b1; tick();
    total++; if (snap_vld !== 1'b1 || snap_cyc !== 32'd12) begin bad++; $display("FAIL b2b_first got=%b/%0d exp=1/12", snap_vld, snap_cyc); end
    tick();
    total++; if (snap_vld !== 1'b1 || snap_cyc !== 32'd13 || snap_cnt !== 32'd9) begin bad++; $display("FAIL b2b_second got=%b/%0d/%0d exp=1/13/9", snap_vld, snap_cyc, snap_cnt); end
    snap = 1'b0; tick();
    total++; if (snap_vld !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", snap_vld); end
  endtask

  task automatic test_rst_clr();
    evt = 4'b0100; sel = 2'd2;
    #3 rst = 1'b1;
    #1;
    total++; if (cycle !== 32'd0 || cnt !== 32'd0 || snap_cyc !== 32'd0) begin bad++; $display("FAIL async_rst got=%0d/%0d/%0d exp=0/0/0", cycle, cnt, snap_cyc); end
    total++; if (state !== 2'b00 || done !== 1'b0) begin bad++; $display("FAIL async_rst_state got=%b/%b exp=00/0", state, done); end
    rst = 1'b0;
    tick();                      // entry
    tick(); tick();
    snap = 1'b1; tick();
    total++; if (snap_cyc !== 32'd2 || snap_vld !== 1'b1) begin bad++; $display("FAIL pre_clr_snap got=%0d/%b exp=2/1", snap_cyc, snap_vld); end
    clr = 1'b1; tick();
    total++; if (snap_vld !== 1'b0 || snap_cyc !== 32'd0 || snap_cnt !== 32'd0) begin bad++; $display("FAIL clr_snap got=%b/%0d/%0d exp=0/0/0", snap_vld, snap_cyc, snap_cnt); end
    total++; if (cycle !== 32'd0 || state !== 2'b00) begin bad++; $display("FAIL clr_state got=%0d/%b exp=0/00", cycle, state); end
    clr = 1'b0; snap = 1'b0; start = 1'b0; evt = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_limit();
    test_freeze();
    test_overflow();
    test_snapshot();
    test_rst_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
